// File: rtl/mt9v034_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mt9v034_pkg
// Purpose  : Shared types and constants for the MT9V034 configuration-bus
//            register writer.
// Revision : 1.0 - initial release
// ============================================================================
package mt9v034_pkg;

    // Writer FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_BIT   = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // 7-bit slave address of the sensor (first wire byte 8'h90 with W bit)
    localparam logic [6:0] MT9V034_DEV_ADDR = 7'h48;

    // Commonly written sensor registers
    localparam logic [7:0] REG_CHIP_CTRL = 8'h07;
    localparam logic [7:0] REG_RESET     = 8'h0C;
    localparam logic [7:0] REG_READ_MODE = 8'h0D;

    // Builds the 32-bit word shifted out MSB first:
    // device address + W, register address, data MSB, data LSB
    function automatic logic [31:0] pack_write(
        input logic [6:0]  dev,
        input logic [7:0]  ra,
        input logic [15:0] rd
    );
        return {dev, 1'b0, ra, rd};
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_phase_tracker.sv
`default_nettype none
// ============================================================================
// Module   : i2c_phase_tracker
// Purpose  : Edge detection on the divider's sclk level plus a counter that
//            marks the middle of each high and low phase.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_phase_tracker #(
    parameter int HOLD = 120
) (
    input  logic clk_24M,
    input  logic reset,
    input  logic sclk,
    output logic rise,
    output logic fall,
    output logic mid_hi,
    output logic mid_lo
);

    localparam logic [8:0] C_MID = 9'(HOLD - 1);

    logic       r_sclk_d;
    logic [8:0] r_cnt;

    assign rise   = sclk & ~r_sclk_d;
    assign fall   = ~sclk & r_sclk_d;
    // The counter never reaches HOLD-1 on an edge cycle because HOLD < 240
    assign mid_hi = sclk & (r_cnt == C_MID);
    assign mid_lo = ~sclk & (r_cnt == C_MID);

    // Delay sclk one cycle and count cycles since the last edge (saturating)
    always_ff @(posedge clk_24M) begin
        if (reset) begin
            r_sclk_d <= 1'b0;
            r_cnt    <= 9'd511;
        end else begin
            r_sclk_d <= sclk;
            if (rise || fall) begin
                r_cnt <= 9'd0;
            end else if (r_cnt != 9'd511) begin
                r_cnt <= r_cnt + 9'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mt9v034_i2c_writer.sv
`default_nettype none
// ============================================================================
// Module   : mt9v034_i2c_writer
// Purpose  : Open-drain two-wire register-write master for the MT9V034.
//            One request = START, addr+W, reg addr, data MSB, data LSB, STOP.
// Revision : 1.0 - initial release
// ============================================================================
module mt9v034_i2c_writer
    import mt9v034_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = MT9V034_DEV_ADDR,
    parameter int         HOLD     = 120
) (
    input  logic        clk_24M,
    input  logic        reset,
    input  logic        sclk,
    input  logic        start,
    input  logic [7:0]  reg_addr,
    input  logic [15:0] reg_data,
    output logic        busy,
    output logic        done,
    output logic        ack_err,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_in
);

    logic w_rise;
    logic w_fall;
    logic w_mid_hi;
    logic w_mid_lo;

    state_t      r_state;
    logic [31:0] r_shift;
    logic [2:0]  r_bit_cnt;
    logic [1:0]  r_byte_cnt;
    logic [1:0]  r_step;     // sub-step inside START / ACK / STOP
    logic        r_follow;   // SCL tracks the divider while set

    i2c_phase_tracker #(
        .HOLD (HOLD)
    ) u_phase (
        .clk_24M (clk_24M),
        .reset   (reset),
        .sclk    (sclk),
        .rise    (w_rise),
        .fall    (w_fall),
        .mid_hi  (w_mid_hi),
        .mid_lo  (w_mid_lo)
    );

    // Transaction sequencer with registered bus and status outputs
    always_ff @(posedge clk_24M) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= 32'd0;
            r_bit_cnt  <= 3'd0;
            r_byte_cnt <= 2'd0;
            r_step     <= 2'd0;
            r_follow   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ack_err    <= 1'b0;
            scl_oe     <= 1'b0;
            sda_oe     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (r_follow) begin
                scl_oe <= ~sclk;
            end
            case (r_state)
                ST_IDLE: begin
                    scl_oe   <= 1'b0;
                    sda_oe   <= 1'b0;
                    r_follow <= 1'b0;
                    if (start) begin
                        r_shift    <= pack_write(DEV_ADDR, reg_addr, reg_data);
                        ack_err    <= 1'b0;
                        busy       <= 1'b1;
                        r_bit_cnt  <= 3'd0;
                        r_byte_cnt <= 2'd0;
                        r_step     <= 2'd0;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    // SDA falls mid-high, then SCL starts toggling at the next fall
                    if (r_step == 2'd0) begin
                        if (w_mid_hi) begin
                            sda_oe <= 1'b1;
                            r_step <= 2'd1;
                        end
                    end else if (w_fall) begin
                        r_follow <= 1'b1;
                        scl_oe   <= 1'b1;
                        r_state  <= ST_BIT;
                    end
                end
                ST_BIT: begin
                    if (w_mid_lo) begin
                        sda_oe <= ~r_shift[31];
                    end
                    if (w_fall) begin
                        r_shift   <= {r_shift[30:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_step  <= 2'd0;
                            r_state <= ST_ACK;
                        end
                    end
                end
                ST_ACK: begin
                    // Release, sample mid-high, then wait for the fall before the
                    // next byte so that fall does not count as a data bit
                    if (r_step == 2'd0) begin
                        if (w_mid_lo) begin
                            sda_oe <= 1'b0;
                            r_step <= 2'd1;
                        end
                    end else if (r_step == 2'd1) begin
                        if (w_mid_hi) begin
                            if (sda_in) begin
                                ack_err <= 1'b1;
                                r_step  <= 2'd0;
                                r_state <= ST_STOP;
                            end else if (r_byte_cnt == 2'd3) begin
                                r_step  <= 2'd0;
                                r_state <= ST_STOP;
                            end else begin
                                r_byte_cnt <= r_byte_cnt + 2'd1;
                                r_step     <= 2'd2;
                            end
                        end
                    end else if (w_fall) begin
                        r_state <= ST_BIT;
                    end
                end
                ST_STOP: begin
                    // SDA low during the last low phase, park SCL high, then SDA rises
                    if (r_step == 2'd0) begin
                        if (w_mid_lo) begin
                            sda_oe <= 1'b1;
                            r_step <= 2'd1;
                        end
                    end else if (r_step == 2'd1) begin
                        if (w_rise) begin
                            r_follow <= 1'b0;
                            scl_oe   <= 1'b0;
                            r_step   <= 2'd2;
                        end
                    end else if (w_mid_hi) begin
                        sda_oe  <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mt9v034_i2c_writer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mt9v034_i2c_writer
// Purpose  : Self-checking bench with a bus-level slave model for the
//            MT9V034 register writer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mt9v034_i2c_writer;

    // sclk half-period in clk_24M cycles (divider's 240 shortened to keep the
    // run short; every timing expectation below is derived from HALF)
    localparam int HALF   = 24;
    localparam int HOLD_T = 12;
    localparam int LAT_MIN = 74 * HALF;   // 37 sclk periods
    localparam int LAT_MAX = 78 * HALF;   // 39 sclk periods

    logic        clk_24M = 1'b0;
    logic        reset = 1'b1;
    logic        sclk = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  reg_addr = 8'h00;
    logic [15:0] reg_data = 16'h0000;
    logic        slave_pull = 1'b0;
    logic        busy, done, ack_err, scl_oe, sda_oe, sda_in;

    assign sda_in = ~(sda_oe | slave_pull);

    mt9v034_i2c_writer #(
        .DEV_ADDR (7'h48),
        .HOLD     (HOLD_T)
    ) dut (
        .clk_24M  (clk_24M),
        .reset    (reset),
        .sclk     (sclk),
        .start    (start),
        .reg_addr (reg_addr),
        .reg_data (reg_data),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .scl_oe   (scl_oe),
        .sda_oe   (sda_oe),
        .sda_in   (sda_in)
    );

    always #21 clk_24M = ~clk_24M;

    // Clock-divider stand-in: sclk level toggling every HALF cycles
    initial begin : sclk_gen
        forever begin
            repeat (HALF) @(negedge clk_24M);
            sclk = ~sclk;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Bus monitor / slave state
    int         k = 0, byte_in = 0, nack_at = -1;
    int         rises = 0, starts = 0, stops = 0, dones = 0, short_ph = 0, phase_len = 0;
    logic [7:0] cur = 8'h00;
    logic       scl_prev = 1'b1, sda_prev = 1'b1;
    logic [7:0] got[$];

    // Decode the wire: START/STOP, bits on SCL rise, ACK/NACK, phase widths
    always @(negedge clk_24M) begin : monitor
        logic scl, sda;
        scl = ~scl_oe;
        sda = ~(sda_oe | slave_pull);
        if (scl != scl_prev) begin
            if (phase_len < HALF) short_ph++;
            phase_len = 1;
        end else begin
            phase_len++;
        end
        if (reset) begin
            k = 0;
            byte_in = 0;
            slave_pull = 1'b0;
        end else if (scl && scl_prev && (sda != sda_prev)) begin
            if (!sda) begin
                starts++;
                k = 0;
                byte_in = 0;
            end else begin
                stops++;
            end
        end else if (scl && !scl_prev) begin
            rises++;
            if (k < 8) cur = {cur[6:0], sda};
            k++;
            if (k == 8) got.push_back(cur);
        end else if (!scl && scl_prev) begin
            if (k == 8) begin
                slave_pull = (byte_in != nack_at);
            end else if (k == 9) begin
                slave_pull = 1'b0;
                k = 0;
                byte_in++;
            end
        end
        if (done) dones++;
        scl_prev = scl;
        sda_prev = sda;
    end

    // Reference: the four bytes a write must put on the wire
    function automatic logic [7:0] exp_byte(input logic [7:0] a, input logic [15:0] d, input int i);
        logic [31:0] w;
        w = {8'h90, a, d};
        return w[31 - 8*i -: 8];
    endfunction

    // Issue one write and wait (bounded) for done; optionally poke start/data mid-flight
    task automatic do_write(input logic [7:0] a, input logic [15:0] d, input int nack, input bit poke,
                            output int lat, output bit tmo, output bit busy1, output bit aerr1,
                            output bit aerr_done, output bit busy_done);
        nack_at  = nack;
        reg_addr = a;
        reg_data = d;
        start    = 1'b1;
        @(negedge clk_24M);
        start = 1'b0;
        busy1 = busy;
        aerr1 = ack_err;
        lat   = 1;
        tmo   = 1'b0;
        while (!done) begin
            if (lat > 100 * HALF) begin
                tmo = 1'b1;
                break;
            end
            @(negedge clk_24M);
            lat++;
            if (poke && lat == 20 * HALF) begin
                start    = 1'b1;
                reg_data = 16'hFFFF;
                reg_addr = 8'hFF;
            end
            if (poke && lat == 20 * HALF + 1) start = 1'b0;
        end
        lat       = lat - 1;
        aerr_done = ack_err;
        busy_done = busy;
        @(negedge clk_24M);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (5) @(negedge clk_24M);
        n_checks++; if (busy !== 1'b0)    $display("FAIL reset_busy: got %b want 0", busy);    else n_pass++;
        n_checks++; if (done !== 1'b0)    $display("FAIL reset_done: got %b want 0", done);    else n_pass++;
        n_checks++; if (ack_err !== 1'b0) $display("FAIL reset_ack_err: got %b want 0", ack_err); else n_pass++;
        n_checks++; if (scl_oe !== 1'b0)  $display("FAIL reset_scl_oe: got %b want 0", scl_oe);  else n_pass++;
        n_checks++; if (sda_oe !== 1'b0)  $display("FAIL reset_sda_oe: got %b want 0", sda_oe);  else n_pass++;
        reset = 1'b0;
        repeat (3) @(negedge clk_24M);
    endtask

    task automatic test_basic();
        int lat, base, r0, s0, p0, d0, nb, bad;
        bit tmo, b1, a1, ad, bd;
        base = got.size(); r0 = rises; s0 = starts; p0 = stops; d0 = dones;
        do_write(8'h0D, 16'h0300, -1, 1'b0, lat, tmo, b1, a1, ad, bd);
        repeat (4 * HALF) @(negedge clk_24M);
        #1;
        nb = got.size() - base;
        bad = 0;
        for (int i = 0; i < 4; i++)
            if (i >= nb || got[base + i] !== exp_byte(8'h0D, 16'h0300, i)) bad++;
        n_checks++; if (tmo)       $display("FAIL basic_timeout: got timeout want done"); else n_pass++;
        n_checks++; if (b1 !== 1'b1) $display("FAIL basic_busy_rise: got %b want 1", b1); else n_pass++;
        n_checks++; if (nb != 4 || bad != 0) $display("FAIL basic_bytes: got %0d bytes %0d wrong want 4 bytes 0 wrong", nb, bad); else n_pass++;
        n_checks++; if ((rises - r0) - (stops - p0) != 36) $display("FAIL basic_pulses: got %0d want 36", (rises - r0) - (stops - p0)); else n_pass++;
        n_checks++; if (dones - d0 != 1) $display("FAIL basic_done_count: got %0d want 1", dones - d0); else n_pass++;
        n_checks++; if (ad !== 1'b0) $display("FAIL basic_ack_err: got %b want 0", ad); else n_pass++;
        n_checks++; if (bd !== 1'b0) $display("FAIL basic_busy_at_done: got %b want 0", bd); else n_pass++;
        n_checks++; if (starts - s0 != 1 || stops - p0 != 1) $display("FAIL basic_start_stop: got %0d/%0d want 1/1", starts - s0, stops - p0); else n_pass++;
        n_checks++; if (lat < LAT_MIN || lat > LAT_MAX) $display("FAIL basic_latency: got %0d want %0d..%0d", lat, LAT_MIN, LAT_MAX); else n_pass++;
    endtask

    task automatic test_nack();
        int lat, base, r0, p0, d0, nb, n;
        bit tmo, b1, a1, ad, bd;
        logic [7:0]  a;
        logic [15:0] d;
        for (int pass = 0; pass < 2; pass++) begin
            n = (pass == 0) ? 0 : int'($urandom_range(1, 3));
            a = 8'($urandom); d = 16'($urandom);
            base = got.size(); r0 = rises; p0 = stops; d0 = dones;
            do_write(a, d, n, 1'b0, lat, tmo, b1, a1, ad, bd);
            repeat (4 * HALF) @(negedge clk_24M);
            #1;
            nb = got.size() - base;
            n_checks++; if (tmo) $display("FAIL nack%0d_timeout: got timeout want done", n); else n_pass++;
            n_checks++; if ((rises - r0) - (stops - p0) != 9 * (n + 1)) $display("FAIL nack%0d_pulses: got %0d want %0d", n, (rises - r0) - (stops - p0), 9 * (n + 1)); else n_pass++;
            n_checks++; if (ad !== 1'b1) $display("FAIL nack%0d_ack_err: got %b want 1", n, ad); else n_pass++;
            n_checks++; if (dones - d0 != 1 || stops - p0 != 1) $display("FAIL nack%0d_done_stop: got %0d/%0d want 1/1", n, dones - d0, stops - p0); else n_pass++;
            n_checks++; if (nb != n + 1 || got[base + n] !== exp_byte(a, d, n)) $display("FAIL nack%0d_bytes: got %0d bytes want %0d", n, nb, n + 1); else n_pass++;
        end
        // sticky flag must clear on the next accepted start
        n_checks++; if (ack_err !== 1'b1) $display("FAIL nack_sticky: got %b want 1", ack_err); else n_pass++;
        do_write(8'($urandom), 16'($urandom), -1, 1'b0, lat, tmo, b1, a1, ad, bd);
        n_checks++; if (a1 !== 1'b0) $display("FAIL nack_clear_on_start: got %b want 0", a1); else n_pass++;
        n_checks++; if (tmo || ad !== 1'b0) $display("FAIL nack_recover: got tmo=%b ack_err=%b want 0/0", tmo, ad); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int lat, base, s0, p0, d0, sh0, bad, tmos;
        bit tmo, b1, a1, ad, bd;
        logic [7:0]  a;
        logic [15:0] d;
        s0 = starts; p0 = stops; d0 = dones; sh0 = short_ph;
        bad = 0; tmos = 0;
        for (int t = 0; t < 10; t++) begin
            a = 8'($urandom); d = 16'($urandom);
            base = got.size();
            do_write(a, d, -1, 1'b0, lat, tmo, b1, a1, ad, bd);
            if (tmo) tmos++;
            if (got.size() - base != 4) bad++;
            else for (int i = 0; i < 4; i++) if (got[base + i] !== exp_byte(a, d, i)) bad++;
        end
        repeat (4 * HALF) @(negedge clk_24M);
        #1;
        n_checks++; if (tmos != 0) $display("FAIL b2b_timeout: got %0d want 0", tmos); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL b2b_bytes: got %0d wrong want 0", bad); else n_pass++;
        n_checks++; if (starts - s0 != 10) $display("FAIL b2b_starts: got %0d want 10", starts - s0); else n_pass++;
        n_checks++; if (stops - p0 != 10) $display("FAIL b2b_stops: got %0d want 10", stops - p0); else n_pass++;
        n_checks++; if (dones - d0 != 10) $display("FAIL b2b_dones: got %0d want 10", dones - d0); else n_pass++;
        n_checks++; if (short_ph - sh0 != 0) $display("FAIL b2b_phase_width: got %0d short phases want 0", short_ph - sh0); else n_pass++;
    endtask

    task automatic test_ignore_start();
        int lat, base, s0, d0, nb, bad;
        bit tmo, b1, a1, ad, bd;
        logic [7:0]  a;
        logic [15:0] d;
        a = 8'($urandom); d = 16'($urandom_range(0, 16'hFFFE));
        base = got.size(); s0 = starts; d0 = dones;
        do_write(a, d, -1, 1'b1, lat, tmo, b1, a1, ad, bd);
        repeat (8 * HALF) @(negedge clk_24M);
        #1;
        nb = got.size() - base;
        bad = 0;
        for (int i = 0; i < 4; i++) if (i >= nb || got[base + i] !== exp_byte(a, d, i)) bad++;
        n_checks++; if (tmo) $display("FAIL ignore_timeout: got timeout want done"); else n_pass++;
        n_checks++; if (nb != 4 || bad != 0) $display("FAIL ignore_bytes: got %0d bytes %0d wrong want 4/0", nb, bad); else n_pass++;
        n_checks++; if (starts - s0 != 1) $display("FAIL ignore_starts: got %0d want 1", starts - s0); else n_pass++;
        n_checks++; if (dones - d0 != 1) $display("FAIL ignore_dones: got %0d want 1", dones - d0); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL ignore_idle_busy: got %b want 0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat, base, wait_cyc, bad;
        bit tmo, b1, a1, ad, bd;
        logic [7:0]  a;
        logic [15:0] d;
        nack_at  = -1;
        reg_addr = 8'($urandom);
        reg_data = 16'($urandom);
        start = 1'b1;
        @(negedge clk_24M);
        start = 1'b0;
        wait_cyc = 0;
        #1;
        while (!(byte_in == 2 && k == 3) && wait_cyc < 100 * HALF) begin
            @(negedge clk_24M);
            #1;
            wait_cyc++;
        end
        n_checks++; if (wait_cyc >= 100 * HALF) $display("FAIL rstmid_reach: got timeout want byte 2 bit 3"); else n_pass++;
        reset = 1'b1;
        @(negedge clk_24M);
        n_checks++; if (scl_oe !== 1'b0 || sda_oe !== 1'b0 || busy !== 1'b0)
            $display("FAIL rstmid_release: got scl_oe=%b sda_oe=%b busy=%b want 0/0/0", scl_oe, sda_oe, busy);
        else n_pass++;
        reset = 1'b0;
        repeat (2) @(negedge clk_24M);
        a = 8'($urandom); d = 16'($urandom);
        base = got.size();
        do_write(a, d, -1, 1'b0, lat, tmo, b1, a1, ad, bd);
        bad = 0;
        if (got.size() - base != 4) bad = 1;
        else for (int i = 0; i < 4; i++) if (got[base + i] !== exp_byte(a, d, i)) bad++;
        n_checks++; if (tmo || ad !== 1'b0) $display("FAIL rstmid_fresh_done: got tmo=%b ack_err=%b want 0/0", tmo, ad); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL rstmid_fresh_bytes: got %0d wrong want 0", bad); else n_pass++;
    endtask

    task automatic test_latency_sweep();
        int lat;
        bit tmo, b1, a1, ad, bd;
        for (int off = 0; off < 8; off++) begin
            @(posedge sclk);
            repeat (off * (2 * HALF / 8) + int'($urandom_range(0, 2 * HALF / 8 - 1))) @(negedge clk_24M);
            do_write(8'($urandom), 16'($urandom), -1, 1'b0, lat, tmo, b1, a1, ad, bd);
            n_checks++; if (tmo) $display("FAIL latency_timeout_%0d: got timeout want done", off); else n_pass++;
            n_checks++; if (lat < LAT_MIN || lat > LAT_MAX) $display("FAIL latency_%0d: got %0d want %0d..%0d", off, lat, LAT_MIN, LAT_MAX); else n_pass++;
        end
    endtask

    initial begin : watchdog
        #(42 * 150000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin : main
        test_reset();
        test_basic();
        test_nack();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_latency_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mt9v034_i2c_writer.md
# mt9v034_i2c_writer

I2C (two-wire) register-write master for the MT9V034 image sensor's configuration bus. It sits directly downstream of the clock divider and consumes that block's 50 kHz `sclk` level output (high for 240 cycles, low for 240 cycles of `clk_24M`) as its bus timebase. Each request writes one 16-bit register: START, device address + W, 8-bit register address, data MSB, data LSB, STOP. Pins are open-drain: the block only drives low or releases.

## Interface
- `DEV_ADDR`, 7'h48, 7-bit sensor slave address; the first byte on the wire is 8'h90.
- `HOLD`, 120, `clk_24M` cycles from an `sclk` edge to the mid-phase action point; legal range 1..239.
- `clk_24M`  in  1  system clock, 24 MHz.
- `reset`  in  1  synchronous, active-high.
- `sclk`  in  1  50 kHz bus timebase from the clock divider, synchronous to `clk_24M`.
- `start`  in  1  write request, sampled only in IDLE.
- `reg_addr`  in  8  register address, captured when `start` is accepted.
- `reg_data`  in  16  register value, captured when `start` is accepted.
- `busy`  out  1  high from the cycle after acceptance through DONE.
- `done`  out  1  one-cycle pulse at the end of a transaction.
- `ack_err`  out  1  sticky NACK flag, cleared on the next accepted `start`.
- `scl_oe`  out  1  1 = pull SCL low.
- `sda_oe`  out  1  1 = pull SDA low.
- `sda_in`  in  1  SDA pad readback, synchronous to `clk_24M`.

## Operation
- Phase tracker:
  - Register `sclk` and detect rise (0→1) and fall (1→0).
  - A 9-bit counter clears on each edge and saturates at 511.
  - `mid_hi` = counter == HOLD−1 while `sclk` is high.
  - `mid_lo` = counter == HOLD−1 while `sclk` is low.
- States and transitions:
  - IDLE: `scl_oe`=0, `sda_oe`=0. On `start`, latch the shift word {DEV_ADDR,0,reg_addr,reg_data} (32 bits), clear `ack_err`, go to START.
  - START: wait for `mid_hi`, then set `sda_oe`=1 (SDA falls while SCL is high). At the next fall, begin following `sclk` (`scl_oe` = ~`sclk`), go to BIT.
  - BIT: at each `mid_lo`, drive `sda_oe` = ~(current MSB of the shift word). At each fall, shift. After 8 bits go to ACK.
  - ACK: at `mid_lo`, release SDA. At `mid_hi`, sample `sda_in`; 1 is a NACK.
    - On NACK: set `ack_err` and go to STOP.
    - Otherwise, go to BIT if bytes remain (4 bytes total), else go to STOP.
  - STOP: at `mid_lo`, set `sda_oe`=1. At the next rise, hold `scl_oe`=0 permanently. At the following `mid_hi`, release SDA (SDA rises while SCL is high), go to DONE.
  - DONE: pulse `done` for 1 cycle, return to IDLE.
- Data order is MSB first, bytes in the order listed.
- `start` during any non-IDLE state is ignored. `reg_addr`/`reg_data` changes after acceptance have no effect.
- Outside START and STOP, SDA changes only at `mid_lo`, i.e. only while SCL is low.

## Timing
- Reset values: `busy`=0, `done`=0, `ack_err`=0, `scl_oe`=0, `sda_oe`=0, state IDLE.
- Reset asserted mid-transaction releases both lines on the next edge of `clk_24M`. The bus is abandoned without a STOP.
- `busy` rises 1 cycle after `start` is sampled in IDLE and falls in the same cycle that `done` pulses.
- A full transaction is 36 SCL pulses: 4 bytes × (8 data + 1 ACK).
- Latency from `start` to `done` is 37–39 `sclk` periods (17 760–18 720 cycles), depending on the `sclk` phase at acceptance.
- A NACK on byte n produces 9·(n+1) SCL pulses followed by STOP. `done` still pulses, with `ack_err`=1.
- Minimum SCL low and high times are 240 cycles (10 µs). SDA hold and setup are both at least HOLD cycles.

## Structure
- Shared package (`mt9v034_pkg`):
  - state enum;
  - `MT9V034_DEV_ADDR` = 7'h48;
  - sensor register address constants (e.g. `REG_CHIP_CTRL` = 8'h07, `REG_RESET` = 8'h0C).
- Sub-module `i2c_phase_tracker`: `sclk` edge detection plus the mid-phase counter, outputting `rise`, `fall`, `mid_hi`, `mid_lo`.
- The top level holds the FSM, the 32-bit shift register, the bit counter (0–7) and the byte counter (0–3).

## Test plan
- Write `reg_addr`=8'h0D, `reg_data`=16'h0300, with the slave model ACKing every byte:
  - decoded bytes are 8'h90, 8'h0D, 8'h03, 8'h00;
  - 36 SCL pulses;
  - exactly one `done` pulse;
  - `ack_err`=0;
  - START and STOP occur with SCL high.
- Slave NACKs the address byte → 9 SCL pulses, then STOP; `ack_err`=1 and `done` pulses once; `ack_err` clears on the next `start`.
- Protocol monitor over 10 back-to-back writes → no SDA transition while SCL is high other than the START and STOP edges; each SCL low/high phase is at least 240 cycles.
- `start` re-asserted mid-transaction, and `reg_data` changed to 16'hFFFF after acceptance → no second transaction begins, and the original data appears on the wire.
- Assert `reset` during bit 3 of byte 2 → one cycle later `scl_oe`=0, `sda_oe`=0, `busy`=0. A fresh `start` then completes normally.
- Sweep `start` across 8 phase offsets of `sclk` → `start`-to-`done` latency stays within 17 760–18 720 cycles.
